// File: rtl/muldiv_defs_pkg.sv
// Shared encodings for the multiply/divide sequencer: instruction ops and FSM states.
package muldiv_defs_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } opE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } stateE;

  // Any encoding outside MULT..MTLO (including 3'b111) behaves as "no op".
  function automatic logic isValidOp(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd6);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Datapath for the iterative multiply/divide: one 2*WIDTH working register shared by
// the shift-add multiplier ({hi,lo} product) and the restoring divider ({rem,quot}),
// plus the final sign correction of the result.
module muldiv_iter_core
  import muldiv_defs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             MulStep,
  input  logic             DivStep,
  input  logic             IsDiv,
  input  logic [WIDTH-1:0] MagA,
  input  logic [WIDTH-1:0] MagB,
  input  logic             NegQ,
  input  logic             NegR,
  output logic [WIDTH-1:0] ResHi,
  output logic [WIDTH-1:0] ResLo
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opB;
  logic               divMode;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     remShift;
  logic [WIDTH:0]     remDiff;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] prodFinal;

  // Single shift-add and single restoring-divide step computed from the current state.
  always_comb begin
    // Multiply: add the multiplicand into the upper half when the LSB of the
    // multiplier is set, then shift the whole accumulator right by one.
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
    mulNext = {mulSum, acc[WIDTH-1:1]};
    // Divide: shift next dividend bit into the remainder and trial-subtract.
    // The remainder is always below the divisor, so remDiff[WIDTH] is set
    // exactly when the trial subtraction went negative.
    remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    remDiff  = remShift - {1'b0, opB};
    if (remDiff[WIDTH]) begin
      divNext = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      divNext = {remDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Working registers: load operands on accept, then advance one step per cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    if (Reset) begin
      acc     <= '0;
      opB     <= '0;
      divMode <= 1'b0;
    end else if (Load) begin
      acc     <= {{WIDTH{1'b0}}, MagA};
      opB     <= MagB;
      divMode <= IsDiv;
    end else if (MulStep) begin
      acc <= mulNext;
    end else if (DivStep) begin
      acc <= divNext;
    end
  end

  // Sign correction applied to the magnitude result during the FIXUP cycle.
  always_comb begin
    prodFinal = NegQ ? -acc : acc;
    if (divMode) begin
      ResLo = NegQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      ResHi = NegR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      ResLo = prodFinal[WIDTH-1:0];
      ResHi = prodFinal[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner beside the EX-stage ALU: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO,
// sequences the iterative core, and stalls the pipeline on HI/LO or unit hazards.
module muldiv_sequencer
  import muldiv_defs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             StartValid,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiLoRead,
  input  logic             Cancel,
  output logic             Stall,
  output logic             Busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  stateE            state;
  stateE            nextState;
  logic [CNT_W-1:0] cnt;
  logic             negQ;
  logic             negR;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             busyReg;
  logic             dbzReg;

  logic             reqValid;
  logic             accept;
  logic             lastIter;
  logic             signedOp;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             coreLoad;
  logic             mulStep;
  logic             divStep;
  logic             hiWe;
  logic             loWe;
  logic [WIDTH-1:0] hiNext;
  logic [WIDTH-1:0] loNext;
  logic             dbzNext;
  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;

  assign reqValid = StartValid & isValidOp(Op);
  assign accept   = reqValid & ~Cancel;
  assign lastIter = (cnt == CNT_W'(WIDTH - 1));
  assign signedOp = isSignedOp(Op);
  assign magA     = (signedOp && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign magB     = (signedOp && OperandB[WIDTH-1]) ? -OperandB : OperandB;

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .Clk     (Clk),
    .Reset   (Reset),
    .Load    (coreLoad),
    .MulStep (mulStep),
    .DivStep (divStep),
    .IsDiv   (isDivOp(Op)),
    .MagA    (magA),
    .MagB    (magB),
    .NegQ    (negQ),
    .NegR    (negR),
    .ResHi   (resHi),
    .ResLo   (resLo)
  );

  // Next-state and datapath control; Cancel aborts any sequence without writing HI/LO.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    nextState = state;
    coreLoad  = 1'b0;
    mulStep   = 1'b0;
    divStep   = 1'b0;
    hiWe      = 1'b0;
    loWe      = 1'b0;
    hiNext    = OperandA;
    loNext    = OperandA;
    dbzNext   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (Op)
            OP_MTHI: hiWe = 1'b1;
            OP_MTLO: loWe = 1'b1;
            OP_MULT, OP_MULTU: begin
              coreLoad  = 1'b1;
              nextState = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (OperandB == '0) begin
                dbzNext = 1'b1;
              end else begin
                coreLoad  = 1'b1;
                nextState = ST_DIV;
              end
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (Cancel) begin
          nextState = ST_IDLE;
        end else begin
          mulStep = 1'b1;
          if (lastIter) nextState = ST_FIXUP;
        end
      end
      ST_DIV: begin
        if (Cancel) begin
          nextState = ST_IDLE;
        end else begin
          divStep = 1'b1;
          if (lastIter) nextState = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        nextState = ST_IDLE;
        if (!Cancel) begin
          hiWe   = 1'b1;
          loWe   = 1'b1;
          hiNext = resHi;
          loNext = resLo;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // FSM state, iteration counter, sign flags and registered status outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      busyReg <= 1'b0;
      dbzReg  <= 1'b0;
    end else begin
      state   <= nextState;
      busyReg <= (nextState != ST_IDLE);
      dbzReg  <= dbzNext;
      if (coreLoad) begin
        cnt  <= '0;
        negQ <= signedOp & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
        negR <= signedOp & OperandA[WIDTH-1];
      end else if (mulStep || divStep) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Architectural HI/LO registers, written by MTHI/MTLO or by FIXUP.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hiReg <= '0;
      loReg <= '0;
    end else begin
      if (hiWe) hiReg <= hiNext;
      if (loWe) loReg <= loNext;
    end
  end

  assign Hi        = hiReg;
  assign Lo        = loReg;
  assign Busy      = busyReg;
  assign DivByZero = dbzReg;
  assign Stall     = busyReg & ~Cancel & (HiLoRead | reqValid);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases followed by
// randomized ops checked against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          StartValid;
  logic [2:0]    Op;
  logic [W-1:0]  OperandA;
  logic [W-1:0]  OperandB;
  logic          HiLoRead;
  logic          Cancel;
  logic          Stall;
  logic          Busy;
  logic [W-1:0]  Hi;
  logic [W-1:0]  Lo;
  logic          DivByZero;

  int            vectors = 0;
  int            miscompares = 0;
  logic [W-1:0]  mHi = '0;
  logic [W-1:0]  mLo = '0;
  logic          mDbz = 1'b0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .StartValid (StartValid),
    .Op         (Op),
    .OperandA   (OperandA),
    .OperandB   (OperandB),
    .HiLoRead   (HiLoRead),
    .Cancel     (Cancel),
    .Stall      (Stall),
    .Busy       (Busy),
    .Hi         (Hi),
    .Lo         (Lo),
    .DivByZero  (DivByZero)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference HI/LO behaviour from the architectural definition of each op.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa;
    longint      sb;
    longint      sp;
    logic [63:0] up;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    mDbz = 1'b0;
    case (op)
      3'd1: begin sp = sa * sb; {mHi, mLo} = sp; end
      3'd2: begin up = {32'b0, a} * {32'b0, b}; {mHi, mLo} = up; end
      3'd3: if (b == 0) mDbz = 1'b1; else begin mLo = 32'(sa / sb); mHi = 32'(sa % sb); end
      3'd4: if (b == 0) mDbz = 1'b1; else begin mLo = a / b; mHi = a % b; end
      3'd5: mHi = a;
      3'd6: mLo = a;
      default: ;
    endcase
  endtask

  // Issue one op, then count cycles until Busy drops (bounded).
  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int cyc, output logic dbzSeen);
    StartValid = 1'b1;
    Op         = op;
    OperandA   = a;
    OperandB   = b;
    model(op, a, b);
    @(posedge Clk); #1;
    StartValid = 1'b0;
    Op         = 3'd0;
    dbzSeen    = DivByZero;
    cyc        = 0;
    while (Busy && cyc < 100) begin
      @(posedge Clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int   cyc;
    int   stallCnt;
    logic dbzSeen;
    logic [2:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    Reset = 1'b1; StartValid = 1'b0; Op = 3'd0; OperandA = '0; OperandB = '0;
    HiLoRead = 1'b0; Cancel = 1'b0;
    #12;
    check("reset_hi", Hi, 32'h0);
    check("reset_lo", Lo, 32'h0);
    check("reset_busy", 32'(Busy), 32'h0);
    check("reset_stall", 32'(Stall), 32'h0);
    check("reset_dbz", 32'(DivByZero), 32'h0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    runOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, dbzSeen);
    check("multu_busy_cycles", 32'(cyc), 32'd33);
    check("multu_hi", Hi, 32'hFFFF_FFFE);
    check("multu_lo", Lo, 32'h0000_0001);

    runOp(3'd1, 32'hFFFF_FFFD, 32'd7, cyc, dbzSeen);
    check("mult_hi", Hi, 32'hFFFF_FFFF);
    check("mult_lo", Lo, 32'hFFFF_FFEB);

    runOp(3'd3, 32'hFFFF_FFF9, 32'd2, cyc, dbzSeen);
    check("div_lo", Lo, 32'hFFFF_FFFD);
    check("div_hi", Hi, 32'hFFFF_FFFF);

    runOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dbzSeen);
    check("div_ovf_lo", Lo, 32'h8000_0000);
    check("div_ovf_hi", Hi, 32'h0);

    runOp(3'd4, 32'd100, 32'd0, cyc, dbzSeen);
    check("divz_pulse", 32'(dbzSeen), 32'h1);
    check("divz_busy_cycles", 32'(cyc), 32'd0);
    @(posedge Clk); #1;
    check("divz_pulse_end", 32'(DivByZero), 32'h0);
    check("divz_hi_kept", Hi, 32'h0);
    check("divz_lo_kept", Lo, 32'h8000_0000);

    // MULT followed by an MFHI/MFLO held in EX from E1.
    StartValid = 1'b1; Op = 3'd1; OperandA = 32'h1234_5678; OperandB = 32'hFEDC_BA98;
    model(3'd1, OperandA, OperandB);
    @(posedge Clk); #1;
    StartValid = 1'b0; Op = 3'd0; HiLoRead = 1'b1;
    stallCnt = 0; cyc = 0;
    while (Busy && cyc < 100) begin
      #1;
      if (Stall) stallCnt++;
      @(posedge Clk); #1;
      cyc++;
    end
    check("read_stall_cycles", 32'(stallCnt), 32'd33);
    check("read_stall_released", 32'(Stall), 32'h0);
    check("read_hi", Hi, mHi);
    check("read_lo", Lo, mLo);
    HiLoRead = 1'b0;

    // Cancel mid-sequence leaves HI/LO untouched.
    runOp(3'd5, 32'h5, 32'h0, cyc, dbzSeen);
    runOp(3'd6, 32'h5, 32'h0, cyc, dbzSeen);
    StartValid = 1'b1; Op = 3'd1; OperandA = 32'd9; OperandB = 32'd9;
    @(posedge Clk); #1;
    StartValid = 1'b0; Op = 3'd0;
    repeat (10) begin @(posedge Clk); #1; end
    check("cancel_busy_before", 32'(Busy), 32'h1);
    Cancel = 1'b1;
    @(posedge Clk); #1;
    Cancel = 1'b0;
    check("cancel_busy", 32'(Busy), 32'h0);
    check("cancel_hi", Hi, 32'h5);
    check("cancel_lo", Lo, 32'h5);
    StartValid = 1'b1; Op = 3'd5; OperandA = 32'h99; Cancel = 1'b1;
    @(posedge Clk); #1;
    StartValid = 1'b0; Op = 3'd0; Cancel = 1'b0;
    check("cancel_idle_hi", Hi, 32'h5);
    check("cancel_idle_busy", 32'(Busy), 32'h0);

    // Asynchronous reset in the middle of a divide.
    StartValid = 1'b1; Op = 3'd3; OperandA = 32'd1000; OperandB = 32'd3;
    @(posedge Clk); #1;
    StartValid = 1'b0; Op = 3'd0;
    repeat (10) begin @(posedge Clk); #1; end
    #2 Reset = 1'b1;
    #1;
    check("areset_busy", 32'(Busy), 32'h0);
    check("areset_hi", Hi, 32'h0);
    check("areset_lo", Lo, 32'h0);
    mHi = '0; mLo = '0;
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
    runOp(3'd6, 32'h1234, 32'h0, cyc, dbzSeen);
    check("areset_mtlo", Lo, 32'h1234);
    check("areset_hi_kept", Hi, 32'h0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      runOp(rop, ra, rb, cyc, dbzSeen);
      check("rand_cycles", 32'(cyc),
            ((rop >= 3'd1 && rop <= 3'd2) || ((rop == 3'd3 || rop == 3'd4) && rb != 0)) ? 32'd33 : 32'd0);
      check("rand_dbz", 32'(dbzSeen), 32'(mDbz));
      check("rand_hi", Hi, mHi);
      check("rand_lo", Lo, mLo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
